// File: rtl/adda_pkg.sv
// Shared definitions for the DAC output / ADC capture paths.
package adda_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } adcState_t;

  localparam int unsigned ADC_DW           = 14;
  localparam int unsigned DAC_DW           = 14;
  localparam int unsigned DEFAULT_DIV      = 4;
  localparam int unsigned DEFAULT_PIPE_LAT = 7;

  // Counter width able to hold 0..n-1 (never below one bit).
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/adc_clk_gen.sv
// ADC sample-clock divider: divCnt, registered ADC clock and capture strobe.
// The capture strobe marks the last clk cycle of each ADC period, where the
// converter output has settled ahead of the next rising ADC clock.
module adc_clk_gen
  import adda_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic active,    // FSM will be in FLUSH/RUN after this edge
  input  logic restart,   // FSM currently in IDLE: start a fresh period
  output logic adcClk,
  output logic capture_c
);

  localparam int unsigned CW = cntWidth(DIV);

  logic [CW-1:0] divCnt;
  logic [CW-1:0] divCntNext;

  // Next divider count: cleared outside FLUSH/RUN and on the entry edge.
  always_comb begin
    divCntNext = '0;
    if (active && !restart) begin
      divCntNext = (divCnt == CW'(DIV - 1)) ? '0 : divCnt + CW'(1);
    end
  end

  // Divider and clock register; the clock is high for the first half period.
  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt <= '0;
      adcClk <= 1'b0;
    end else begin
      divCnt <= divCntNext;
      adcClk <= active && (divCntNext < CW'(DIV / 2));
    end
  end

  assign capture_c = (divCnt == CW'(DIV - 1));

endmodule

// File: rtl/adc_capture.sv
// Dual-channel 14-bit pipelined ADC capture: generates the ADC clock, drops
// the pipeline-latency samples after enable and delivers A/B pairs with a
// one-cycle valid strobe plus sticky overrange flags.
// Build option: ADC_TWOS_COMP_EN converts offset binary to two's complement
// (MSB inverted) on capture; undefined passes raw data through.
module adc_capture
  import adda_pkg::*;
#(
  parameter int unsigned DIV      = DEFAULT_DIV,
  parameter int unsigned PIPE_LAT = DEFAULT_PIPE_LAT,
  parameter int unsigned DW       = ADC_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [DW-1:0] adc_dataA_in,
  input  logic [DW-1:0] adc_dataB_in,
  input  logic          adc_otrA_in,
  input  logic          adc_otrB_in,
  input  logic          ovr_clear,
  output logic          adc_clk_out,
  output logic          adc_pdwn_out,
  output logic [DW-1:0] adc_dataA,
  output logic [DW-1:0] adc_dataB,
  output logic          adc_valid,
  output logic          ovrA,
  output logic          ovrB,
  output logic          busy
);

  localparam int unsigned FW = cntWidth(PIPE_LAT);

  adcState_t     state;
  adcState_t     nextState;
  logic [FW-1:0] flushCnt;
  logic [FW-1:0] flushCntNext;
  logic          capture_c;
  logic          active_c;
  logic          restart_c;
  logic [DW-1:0] sampleA_c;
  logic [DW-1:0] sampleB_c;
  logic [DW-1:0] dataANext;
  logic [DW-1:0] dataBNext;
  logic          validNext;
  logic          ovrANext;
  logic          ovrBNext;

  assign active_c  = (nextState != IDLE);
  assign restart_c = (state == IDLE);

  adc_clk_gen #(
    .DIV(DIV)
  ) uClkGen (
    .clk      (clk),
    .rst      (rst),
    .active   (active_c),
    .restart  (restart_c),
    .adcClk   (adc_clk_out),
    .capture_c(capture_c)
  );

`ifdef ADC_TWOS_COMP_EN
  assign sampleA_c = {~adc_dataA_in[DW-1], adc_dataA_in[DW-2:0]};
  assign sampleB_c = {~adc_dataB_in[DW-1], adc_dataB_in[DW-2:0]};
`else
  assign sampleA_c = adc_dataA_in;
  assign sampleB_c = adc_dataB_in;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state: dropping enable always returns to IDLE on the next edge.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (enable) nextState = FLUSH;
      FLUSH: begin
        if (!enable) begin
          nextState = IDLE;
        end else if (capture_c && (flushCnt == FW'(PIPE_LAT - 1))) begin
          nextState = RUN;
        end
      end
      RUN:     if (!enable) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output/datapath next values; a capture with enable low is discarded.
  always_comb begin
    flushCntNext = '0;
    dataANext    = adc_dataA;
    dataBNext    = adc_dataB;
    validNext    = 1'b0;
    ovrANext     = ovrA & ~ovr_clear;
    ovrBNext     = ovrB & ~ovr_clear;
    unique case (state)
      FLUSH: begin
        flushCntNext = flushCnt;
        if (enable && capture_c) flushCntNext = flushCnt + FW'(1);
      end
      RUN: begin
        if (enable && capture_c) begin
          dataANext = sampleA_c;
          dataBNext = sampleB_c;
          validNext = 1'b1;
          ovrANext  = ovrANext | adc_otrA_in;
          ovrBNext  = ovrBNext | adc_otrB_in;
        end
      end
      default: ;
    endcase
  end

  // Output registers; status outputs track the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      flushCnt     <= '0;
      adc_dataA    <= '0;
      adc_dataB    <= '0;
      adc_valid    <= 1'b0;
      ovrA         <= 1'b0;
      ovrB         <= 1'b0;
      busy         <= 1'b0;
      adc_pdwn_out <= 1'b1;
    end else begin
      flushCnt     <= flushCntNext;
      adc_dataA    <= dataANext;
      adc_dataB    <= dataBNext;
      adc_valid    <= validNext;
      ovrA         <= ovrANext;
      ovrB         <= ovrBNext;
      busy         <= active_c;
      adc_pdwn_out <= ~active_c;
    end
  end

endmodule

// File: doc/adc_capture.md
Name: adc_capture

Overview:
- Receive-side counterpart of the dual-channel 14-bit DAC output path: drives a dual 14-bit parallel pipelined ADC and captures its samples.
- Generates the ADC sample clock from the system clock and discards the converter's pipeline-latency samples after enable.
- Presents aligned A/B sample pairs with a one-cycle valid strobe to downstream DSP logic, and tracks out-of-range events.

Parameters:
- DIV, 4: ADC clock period in clk cycles; even, >= 2.
- PIPE_LAT, 7: ADC pipeline latency in conversions; samples discarded after enable.
- DW, 14: ADC data width per channel.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run conversions.
- adc_dataA_in  in  DW  channel A parallel data from the ADC.
- adc_dataB_in  in  DW  channel B parallel data from the ADC.
- adc_otrA_in  in  1  channel A out-of-range pin.
- adc_otrB_in  in  1  channel B out-of-range pin.
- ovr_clear  in  1  pulse; clears sticky overrange flags.
- adc_clk_out  out  1  ADC sample clock.
- adc_pdwn_out  out  1  ADC power-down; 1 when not in RUN or FLUSH.
- adc_dataA  out  DW  captured channel A sample.
- adc_dataB  out  DW  captured channel B sample.
- adc_valid  out  1  one-cycle strobe; new A/B pair on adc_dataA/adc_dataB.
- ovrA  out  1  sticky channel A overrange.
- ovrB  out  1  sticky channel B overrange.
- busy  out  1  1 while in FLUSH or RUN.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State IDLE; div_cnt=0; flush_cnt=0.
  - adc_clk_out=0, adc_pdwn_out=1, adc_dataA=0, adc_dataB=0, adc_valid=0, ovrA=0, ovrB=0, busy=0.
  - Reset mid-operation aborts immediately with the same values.
- div_cnt:
  - Counts 0..DIV-1 and wraps, only in FLUSH and RUN; held at 0 in IDLE.
  - adc_clk_out is registered: 1 for div_cnt in [0, DIV/2-1], 0 otherwise; 0 in IDLE.
- Capture point: the clk edge where div_cnt==DIV-1 (last cycle before the next rising adc_clk_out, data settled).
- States:
  - IDLE: adc_pdwn_out=1. If enable=1, go to FLUSH with flush_cnt=0 and div_cnt=0.
  - FLUSH: adc_pdwn_out=0. Each capture point increments flush_cnt; no adc_valid, data outputs hold. When a capture point occurs with flush_cnt==PIPE_LAT-1, go to RUN.
  - RUN: at each capture point, on the next edge:
    - adc_dataA<=adc_dataA_in and adc_dataB<=adc_dataB_in;
    - adc_valid=1 for exactly one cycle;
    - ovrA|=adc_otrA_in and ovrB|=adc_otrB_in.
  - enable=0 in FLUSH or RUN: go to IDLE on the next edge; a capture point in that same cycle is discarded. Data outputs hold their last values.
- Timing:
  - adc_valid period = DIV clk cycles.
  - First adc_valid occurs (PIPE_LAT+1)*DIV cycles after the edge that leaves IDLE.
- ovr_clear:
  - Clears ovrA/ovrB on the next edge.
  - If it coincides with a capture that sets a flag, the set wins (flag reads 1).
  - Flags are also sampled only at capture points, never in FLUSH.
- busy = (state != IDLE), registered.
- DIV=2 is legal: adc_clk_out toggles every cycle and every other cycle is a capture point.

Optional Feature:
- Macro ADC_TWOS_COMP_EN.
- Defined: captured data is converted from offset binary to two's complement (MSB inverted) before registering. Example: input 14'h2000 yields 14'h0000; input 14'h0000 yields 14'h2000.
- Undefined: raw offset-binary data is passed through unchanged.
- Timing is identical in both builds.

Decomposition:
- Shared package adda_pkg holds:
  - state enum {IDLE, FLUSH, RUN};
  - ADC_DW=14 (shared with the DAC path DAC_DW=14);
  - default DIV and PIPE_LAT constants.
- Sub-module adc_clk_gen: div_cnt, adc_clk_out and the capture-point strobe. The top holds the FSM, data and flag registers.

Test Plan:
- Reset, then enable=1, DIV=4, PIPE_LAT=7, ramp input from 0 (+1 per ADC clock) -> first adc_valid 32 cycles after FSM leaves IDLE; adc_valid every 4 cycles; adc_pdwn_out=0.
- Hold adc_dataA_in=14'h1ABC and adc_dataB_in=14'h0123 in RUN -> outputs equal these values on each adc_valid; with ADC_TWOS_COMP_EN, outputs are 14'h3ABC and 14'h2123.
- Drive adc_otrA_in=1 for one capture in RUN -> ovrA=1 and stays 1; pulse ovr_clear -> ovrA=0. Pulse ovr_clear together with otrA at a capture -> ovrA=1.
- Drive adc_otrB_in=1 during FLUSH only -> ovrB stays 0.
- Deassert enable mid-RUN at a capture point -> no adc_valid that cycle; IDLE next edge; adc_clk_out=0, adc_pdwn_out=1, data held. Re-enable -> full PIPE_LAT flush repeats.
- Assert rst mid-FLUSH -> all outputs take reset values next edge. DIV=2 regression -> adc_valid every 2 cycles, first at 16 cycles.
